// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared types and constants for the vscale instruction/data memory arbiter.
// Build option: VSCALE_MEM_ARB_RR_EN (anti-starvation for the fetch port).
package vscale_mem_arbiter_pkg;

  localparam int ARB_OWNER_WIDTH  = 2;
  localparam int ARB_STARVE_WIDTH = 3;

  localparam logic [2:0] MEM_SIZE_WORD = 3'd2;

  typedef enum logic [ARB_OWNER_WIDTH-1:0] {
    ARB_NONE    = 2'd0,
    ARB_IMEM    = 2'd1,
    ARB_DMEM_RD = 2'd2,
    ARB_DMEM_WR = 2'd3
  } arb_owner_e;

  function automatic logic is_dmem(arb_owner_e owner);
    return (owner == ARB_DMEM_RD) || (owner == ARB_DMEM_WR);
  endfunction

endpackage

// File: rtl/vscale_mem_arbiter_grant.sv
// Address-phase grant for the shared memory bus, plus the fetch starvation counter.
// Build option: VSCALE_MEM_ARB_RR_EN enables the counter; otherwise strict dmem > imem.
import vscale_mem_arbiter_pkg::*;

module vscale_mem_arbiter_grant #(
  parameter int MAX_STARVE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       imem_req_i,
  input  logic                       dmem_en_i,
  input  logic                       dmem_wen_i,
  input  logic                       mem_wait_i,
  output logic [ARB_OWNER_WIDTH-1:0] grant_o
);

  arb_owner_e grant_q, grant_d;
  logic       force_imem;

`ifdef VSCALE_MEM_ARB_RR_EN
  logic [ARB_STARVE_WIDTH-1:0] starve_q, starve_d;

  assign force_imem = (starve_q == ARB_STARVE_WIDTH'(MAX_STARVE));
`else
  // Fixed priority: the fetch port is never promoted.
  assign force_imem = (MAX_STARVE < 0);
`endif

  always_comb begin
    grant_d = ARB_NONE;
    if (mem_wait_i) begin
      grant_d = grant_q;
    end else if (dmem_en_i && !(force_imem && imem_req_i)) begin
      grant_d = dmem_wen_i ? ARB_DMEM_WR : ARB_DMEM_RD;
    end else if (imem_req_i) begin
      grant_d = ARB_IMEM;
    end
  end

`ifdef VSCALE_MEM_ARB_RR_EN
  always_comb begin
    starve_d = starve_q;
    if (!mem_wait_i) begin
      if (grant_d == ARB_IMEM) begin
        starve_d = '0;
      end else if (imem_req_i && is_dmem(grant_d) && !force_imem) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) grant_q <= ARB_NONE;
    else       grant_q <= grant_d;
  end

  assign grant_o = grant_d;

endmodule

// File: rtl/vscale_mem_arbiter.sv
// Shares one two-phase memory bus between the vscale fetch and data ports.
// Build option: VSCALE_MEM_ARB_RR_EN (see vscale_mem_arbiter_grant).
import vscale_mem_arbiter_pkg::*;

module vscale_mem_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int XPR_LEN    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_req,
  input  logic [XPR_LEN-1:0] imem_addr,
  output logic [XPR_LEN-1:0] imem_rdata,
  output logic               imem_wait,
  output logic               imem_badmem_e,
  input  logic               dmem_en,
  input  logic               dmem_wen,
  input  logic [2:0]         dmem_size,
  input  logic [XPR_LEN-1:0] dmem_addr,
  input  logic [XPR_LEN-1:0] dmem_wdata_delayed,
  output logic [XPR_LEN-1:0] dmem_rdata,
  output logic               dmem_wait,
  output logic               dmem_badmem_e,
  output logic               mem_en,
  output logic               mem_wen,
  output logic [2:0]         mem_size,
  output logic [XPR_LEN-1:0] mem_addr,
  output logic [XPR_LEN-1:0] mem_wdata_delayed,
  input  logic [XPR_LEN-1:0] mem_rdata,
  input  logic               mem_wait,
  input  logic               mem_badmem_e
);

  logic [ARB_OWNER_WIDTH-1:0] grant_raw;
  arb_owner_e                 grant;
  arb_owner_e                 dphase_q;
  logic                       imem_req_q;
  logic                       dmem_en_q;

  vscale_mem_arbiter_grant #(
    .MAX_STARVE (MAX_STARVE)
  ) u_grant (
    .clk        (clk),
    .reset      (reset),
    .imem_req_i (imem_req),
    .dmem_en_i  (dmem_en),
    .dmem_wen_i (dmem_wen),
    .mem_wait_i (mem_wait),
    .grant_o    (grant_raw)
  );

  assign grant = arb_owner_e'(grant_raw);

  assign mem_en   = (grant != ARB_NONE) && !reset;
  assign mem_wen  = (grant == ARB_DMEM_WR) && !reset;
  assign mem_addr = is_dmem(grant)      ? dmem_addr :
                    (grant == ARB_IMEM) ? imem_addr : '0;
  assign mem_size = is_dmem(grant)      ? dmem_size :
                    (grant == ARB_IMEM) ? MEM_SIZE_WORD : 3'd0;

  // A stalled data phase keeps its owner; the next address phase is not accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      dphase_q   <= ARB_NONE;
      imem_req_q <= 1'b0;
      dmem_en_q  <= 1'b0;
    end else if (!mem_wait) begin
      dphase_q   <= grant;
      imem_req_q <= imem_req;
      dmem_en_q  <= dmem_en;
    end
  end

  assign mem_wdata_delayed = (dphase_q == ARB_DMEM_WR) ? dmem_wdata_delayed : '0;

  assign imem_rdata    = mem_rdata;
  assign dmem_rdata    = mem_rdata;
  assign imem_badmem_e = mem_badmem_e && (dphase_q == ARB_IMEM);
  assign dmem_badmem_e = mem_badmem_e && is_dmem(dphase_q);

  assign imem_wait = mem_wait || (imem_req_q && (dphase_q != ARB_IMEM));
  assign dmem_wait = mem_wait || (dmem_en_q && !is_dmem(dphase_q));

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed plus randomized bench for vscale_mem_arbiter against a behavioural bus model.
// Honours VSCALE_MEM_ARB_RR_EN when defined on the command line.
`timescale 1ns/1ps
module tb_vscale_mem_arbiter;

  localparam int XL = 32;
  localparam int MS = 4;
`ifdef VSCALE_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // owner codes used by the model: 0 none, 1 fetch, 2 load, 3 store
  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req, dmem_en, dmem_wen, mem_wait, mem_badmem_e;
  logic [2:0]    dmem_size;
  logic [XL-1:0] imem_addr, dmem_addr, dmem_wdata_delayed, mem_rdata;
  logic [XL-1:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata_delayed;
  logic          imem_wait, imem_badmem_e, dmem_wait, dmem_badmem_e;
  logic          mem_en, mem_wen;
  logic [2:0]    mem_size;

  always #5 clk = ~clk;

  vscale_mem_arbiter #(.MAX_STARVE(MS), .XPR_LEN(XL)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .imem_wait          (imem_wait),
    .imem_badmem_e      (imem_badmem_e),
    .dmem_en            (dmem_en),
    .dmem_wen           (dmem_wen),
    .dmem_size          (dmem_size),
    .dmem_addr          (dmem_addr),
    .dmem_wdata_delayed (dmem_wdata_delayed),
    .dmem_rdata         (dmem_rdata),
    .dmem_wait          (dmem_wait),
    .dmem_badmem_e      (dmem_badmem_e),
    .mem_en             (mem_en),
    .mem_wen            (mem_wen),
    .mem_size           (mem_size),
    .mem_addr           (mem_addr),
    .mem_wdata_delayed  (mem_wdata_delayed),
    .mem_rdata          (mem_rdata),
    .mem_wait           (mem_wait),
    .mem_badmem_e       (mem_badmem_e)
  );

  int n_vec = 0;
  int n_err = 0;

  // model state: who holds the address phase, who owns the data phase, pending requests
  int m_addr_owner = 0;
  int m_data_owner = 0;
  int m_starve     = 0;
  bit m_ireq_q     = 1'b0;
  bit m_den_q      = 1'b0;

  bit count_dmem   = 1'b0;
  int completions  = 0;
  int t5_idx       = 0;
  int t5_first     = 0;

  task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int exp_owner();
    if (mem_wait) return m_addr_owner;
    if (dmem_en && !(RR && imem_req && (m_starve == MS))) return dmem_wen ? 3 : 2;
    if (imem_req) return 1;
    return 0;
  endfunction

  task automatic check_outputs();
    int g;
    bit en;
    g  = exp_owner();
    en = (g != 0) && !reset;
    chk("mem_en",  {31'd0, mem_en},  {31'd0, en});
    chk("mem_wen", {31'd0, mem_wen}, {31'd0, (g == 3) && !reset});
    if (en) begin
      chk("mem_addr", mem_addr, (g == 1) ? imem_addr : dmem_addr);
      chk("mem_size", {29'd0, mem_size}, {29'd0, (g == 1) ? 3'd2 : dmem_size});
    end
    chk("mem_wdata_delayed", mem_wdata_delayed, (m_data_owner == 3) ? dmem_wdata_delayed : '0);
    chk("imem_wait", {31'd0, imem_wait}, {31'd0, mem_wait || (m_ireq_q && m_data_owner != 1)});
    chk("dmem_wait", {31'd0, dmem_wait}, {31'd0, mem_wait || (m_den_q && m_data_owner < 2)});
    chk("imem_badmem_e", {31'd0, imem_badmem_e}, {31'd0, mem_badmem_e && m_data_owner == 1});
    chk("dmem_badmem_e", {31'd0, dmem_badmem_e}, {31'd0, mem_badmem_e && m_data_owner >= 2});
    chk("imem_rdata", imem_rdata, mem_rdata);
    chk("dmem_rdata", dmem_rdata, mem_rdata);
  endtask

  task automatic model_update();
    int g;
    if (reset) begin
      m_addr_owner = 0;
      m_data_owner = 0;
      m_starve     = 0;
      m_ireq_q     = 1'b0;
      m_den_q      = 1'b0;
    end else begin
      g = exp_owner();
      if (!mem_wait) begin
        if (RR) begin
          if (g == 1) m_starve = 0;
          else if (imem_req && g >= 2 && m_starve < MS) m_starve++;
        end
        m_data_owner = g;
        m_ireq_q     = imem_req;
        m_den_q      = dmem_en;
      end
      m_addr_owner = g;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    if (count_dmem && !dmem_wait) completions++;
    if (t5_idx > 0 && t5_first == 0 && mem_en && mem_addr == 32'h1000) t5_first = t5_idx;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_req = 1'b0; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd2;
    imem_addr = '0; dmem_addr = '0; dmem_wdata_delayed = '0; mem_rdata = '0;
    mem_wait = 1'b0; mem_badmem_e = 1'b0;
    cyc(); cyc();

    // fetch-only stream
    reset = 1'b0; imem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_addr = 32'(i * 4); mem_rdata = $urandom;
      cyc();
    end

    // contested load then fetch retry
    dmem_en = 1'b1; dmem_addr = 32'h100; imem_addr = 32'h4; cyc();
    dmem_en = 1'b0; mem_rdata = $urandom; cyc();
    imem_addr = 32'h8; cyc();

    // store with delayed data
    imem_req = 1'b0; dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h200; cyc();
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = 32'hDEADBEEF; cyc();
    cyc();

    // three-cycle memory stall on a load
    dmem_en = 1'b1; dmem_addr = 32'h300; cyc();
    count_dmem = 1'b1; mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_addr_held", mem_addr, 32'h300);
    end
    mem_wait = 1'b0; dmem_en = 1'b0; cyc();
    count_dmem = 1'b0;
    chk("t4_completions", 32'(completions), 32'd1);

    // back-to-back loads against a waiting fetch
    reset = 1'b1; cyc();
    reset = 1'b0; imem_req = 1'b1; imem_addr = 32'h1000; dmem_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      t5_idx = i; dmem_addr = 32'h2000 + 32'(i * 4);
      cyc();
    end
    t5_idx = 0;
    chk("t5_first_imem_win", 32'(t5_first), RR ? 32'd5 : 32'd0);

    // reset during a store data phase
    imem_req = 1'b0; dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h400; cyc();
    reset = 1'b1; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = 32'hCAFEF00D; cyc();
    reset = 1'b0; mem_badmem_e = 1'b1;
    @(negedge clk);
    chk("t6_mem_en", {31'd0, mem_en}, 32'd0);
    chk("t6_imem_wait", {31'd0, imem_wait}, 32'd0);
    chk("t6_dmem_wait", {31'd0, dmem_wait}, 32'd0);
    chk("t6_imem_badmem", {31'd0, imem_badmem_e}, 32'd0);
    chk("t6_dmem_badmem", {31'd0, dmem_badmem_e}, 32'd0);
    chk("t6_wdata", mem_wdata_delayed, 32'd0);
    check_outputs();
    @(posedge clk); model_update(); #1;

    // randomized traffic with stalls and occasional reset
    for (int i = 0; i < 400; i++) begin
      mem_wait = ($urandom_range(0, 3) == 0);
      if (!mem_wait) begin
        imem_req  = ($urandom_range(0, 3) != 0);
        dmem_en   = $urandom_range(0, 1) == 1;
        dmem_wen  = $urandom_range(0, 1) == 1;
        dmem_size = 3'($urandom_range(0, 2));
        imem_addr = $urandom & 32'hFFFF_FFFC;
        dmem_addr = $urandom;
      end
      dmem_wdata_delayed = $urandom;
      mem_rdata          = $urandom;
      mem_badmem_e       = ($urandom_range(0, 7) == 0);
      reset              = ($urandom_range(0, 59) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
